// File: rtl/regmap_pkg.sv
// Shared constants, FSM state types and byte-lane merge helper
// for the parametrised AXI-lite register map.
package regmap_pkg;

  localparam logic [31:0] PCORE_VERSION = 32'h0001_0300;

  localparam int ADDR_VERSION     = 'h000;
  localparam int ADDR_ID          = 'h001;
  localparam int ADDR_MAGIC       = 'h003;
  localparam int ADDR_EVT_STATUS  = 'h004;
  localparam int ADDR_EVT_MASK    = 'h005;
  localparam int ADDR_STATUS_BASE = 'h010;
  localparam int ADDR_CTRL_BASE   = 'h040;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic [31:0] apply_wstrb(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_slave_core.sv
// AXI-lite slave handshake engine: write and read FSMs, exposing
// a one-cycle write strobe and a combinational read request.
module axi_lite_slave_core
  import regmap_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_if_awaddr,
  input  logic                     s_axi_if_awvalid,
  output logic                     s_axi_if_awready,
  input  logic [31:0]              s_axi_if_wdata,
  input  logic [3:0]               s_axi_if_wstrb,
  input  logic                     s_axi_if_wvalid,
  output logic                     s_axi_if_wready,
  output logic [1:0]               s_axi_if_bresp,
  output logic                     s_axi_if_bvalid,
  input  logic                     s_axi_if_bready,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_if_araddr,
  input  logic                     s_axi_if_arvalid,
  output logic                     s_axi_if_arready,
  output logic [31:0]              s_axi_if_rdata,
  output logic [1:0]               s_axi_if_rresp,
  output logic                     s_axi_if_rvalid,
  input  logic                     s_axi_if_rready,
  output logic                     wreq,
  output logic [ADDRESS_WIDTH-3:0] waddr,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  input  logic                     werr,
  output logic                     rreq,
  output logic [ADDRESS_WIDTH-3:0] raddr,
  input  logic [31:0]              rdata,
  input  logic                     rerr
);

  wr_state_t wst, wst_nxt;
  rd_state_t rst, rst_nxt;

  logic                     aw_full, w_full;
  logic                     aw_hs, w_hs, ar_hs;
  logic [ADDRESS_WIDTH-3:0] aw_q;
  logic [31:0]              wd_q;
  logic [3:0]               ws_q;
  logic [1:0]               bresp_q, rresp_q;
  logic [31:0]              rdata_q;
  logic                     unused_lsb;

  assign unused_lsb = ^{s_axi_if_awaddr[1:0],
                        s_axi_if_araddr[1:0]};

  assign s_axi_if_awready = !reset_i && wst == W_IDLE && !aw_full;
  assign s_axi_if_wready  = !reset_i && wst == W_IDLE && !w_full;
  assign s_axi_if_arready = !reset_i && rst == R_IDLE;

  assign aw_hs = s_axi_if_awvalid && s_axi_if_awready;
  assign w_hs  = s_axi_if_wvalid && s_axi_if_wready;
  assign ar_hs = s_axi_if_arvalid && s_axi_if_arready;

  assign wreq  = wst == W_EXEC;
  assign waddr = aw_q;
  assign wdata = wd_q;
  assign wstrb = ws_q;

  assign rreq  = ar_hs;
  assign raddr = s_axi_if_araddr[ADDRESS_WIDTH-1:2];

  assign s_axi_if_bvalid = wst == W_RESP;
  assign s_axi_if_bresp  = bresp_q;
  assign s_axi_if_rvalid = rst == R_DATA;
  assign s_axi_if_rdata  = rdata_q;
  assign s_axi_if_rresp  = rresp_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wst <= W_IDLE;
      rst <= R_IDLE;
    end else begin
      wst <= wst_nxt;
      rst <= rst_nxt;
    end
  end

  // Execute as soon as the second half of the pair lands
  always_comb begin
    wst_nxt = wst;
    unique case (wst)
      W_IDLE:
        if ((aw_full || aw_hs) && (w_full || w_hs))
          wst_nxt = W_EXEC;
      W_EXEC: wst_nxt = W_RESP;
      W_RESP:
        if (s_axi_if_bready) wst_nxt = W_IDLE;
      default: wst_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rst_nxt = rst;
    unique case (rst)
      R_IDLE: if (ar_hs) rst_nxt = R_DATA;
      R_DATA: if (s_axi_if_rready) rst_nxt = R_IDLE;
      default: rst_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_q    <= '0;
      wd_q    <= '0;
      ws_q    <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_q    <= s_axi_if_awaddr[ADDRESS_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        wd_q   <= s_axi_if_wdata;
        ws_q   <= s_axi_if_wstrb;
      end
      if (wst == W_EXEC) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bresp_q <= werr ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rerr ? 32'h0 : rdata;
      rresp_q <= rerr ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: rtl/param_regmap.sv
// Parametrised AXI-lite register map: control words, status words,
// sticky W1C events with masked, registered interrupt.
module param_regmap
  import regmap_pkg::*;
#(
  parameter logic [31:0]          ID            = 32'h0,
  parameter int                   ADDRESS_WIDTH = 11,
  parameter logic [31:0]          MAGIC         = 32'h0,
  parameter int                   N_RW          = 4,
  parameter int                   N_RO          = 4,
  parameter int                   N_EVT         = 8,
  parameter logic [N_RW*32-1:0]   CTRL_RESET    = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_if_awaddr,
  input  logic                     s_axi_if_awvalid,
  output logic                     s_axi_if_awready,
  input  logic [31:0]              s_axi_if_wdata,
  input  logic [3:0]               s_axi_if_wstrb,
  input  logic                     s_axi_if_wvalid,
  output logic                     s_axi_if_wready,
  output logic [1:0]               s_axi_if_bresp,
  output logic                     s_axi_if_bvalid,
  input  logic                     s_axi_if_bready,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_if_araddr,
  input  logic                     s_axi_if_arvalid,
  output logic                     s_axi_if_arready,
  output logic [31:0]              s_axi_if_rdata,
  output logic [1:0]               s_axi_if_rresp,
  output logic                     s_axi_if_rvalid,
  input  logic                     s_axi_if_rready,
  input  logic [N_RO*32-1:0]       status_i,
  input  logic [N_EVT-1:0]         event_i,
  output logic [N_RW*32-1:0]       ctrl_o,
  output logic [N_RW-1:0]          ctrl_wr_o,
  output logic                     irq_o
);

  localparam int WA = ADDRESS_WIDTH - 2;

  logic          wreq, rreq, werr, rerr;
  logic [WA-1:0] waddr, raddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;

  logic [N_RW*32-1:0] ctrl_q;
  logic [N_RW-1:0]    ctrl_wr_q, ctrl_hit;
  logic [N_EVT-1:0]   evt_status, evt_mask, evt_clr;
  logic               mask_hit, evt_hit, irq_q;
  logic               unused_rreq;

  assign unused_rreq = rreq;

  axi_lite_slave_core #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_core (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .s_axi_if_awaddr  (s_axi_if_awaddr),
    .s_axi_if_awvalid (s_axi_if_awvalid),
    .s_axi_if_awready (s_axi_if_awready),
    .s_axi_if_wdata   (s_axi_if_wdata),
    .s_axi_if_wstrb   (s_axi_if_wstrb),
    .s_axi_if_wvalid  (s_axi_if_wvalid),
    .s_axi_if_wready  (s_axi_if_wready),
    .s_axi_if_bresp   (s_axi_if_bresp),
    .s_axi_if_bvalid  (s_axi_if_bvalid),
    .s_axi_if_bready  (s_axi_if_bready),
    .s_axi_if_araddr  (s_axi_if_araddr),
    .s_axi_if_arvalid (s_axi_if_arvalid),
    .s_axi_if_arready (s_axi_if_arready),
    .s_axi_if_rdata   (s_axi_if_rdata),
    .s_axi_if_rresp   (s_axi_if_rresp),
    .s_axi_if_rvalid  (s_axi_if_rvalid),
    .s_axi_if_rready  (s_axi_if_rready),
    .wreq             (wreq),
    .waddr            (waddr),
    .wdata            (wdata),
    .wstrb            (wstrb),
    .werr             (werr),
    .rreq             (rreq),
    .raddr            (raddr),
    .rdata            (rdata),
    .rerr             (rerr)
  );

  always_comb begin
    ctrl_hit = '0;
    mask_hit = int'(waddr) == ADDR_EVT_MASK;
    evt_hit  = int'(waddr) == ADDR_EVT_STATUS;
    for (int i = 0; i < N_RW; i++) begin
      if (int'(waddr) == ADDR_CTRL_BASE + i)
        ctrl_hit[i] = 1'b1;
    end
    werr = !(|ctrl_hit || mask_hit || evt_hit);
  end

  always_comb begin
    rdata = '0;
    rerr  = 1'b1;
    if (int'(raddr) == ADDR_VERSION) begin
      rdata = PCORE_VERSION;
      rerr  = 1'b0;
    end
    if (int'(raddr) == ADDR_ID) begin
      rdata = ID;
      rerr  = 1'b0;
    end
    if (int'(raddr) == ADDR_MAGIC) begin
      rdata = MAGIC;
      rerr  = 1'b0;
    end
    if (int'(raddr) == ADDR_EVT_STATUS) begin
      rdata = 32'(evt_status);
      rerr  = 1'b0;
    end
    if (int'(raddr) == ADDR_EVT_MASK) begin
      rdata = 32'(evt_mask);
      rerr  = 1'b0;
    end
    for (int i = 0; i < N_RO; i++) begin
      if (int'(raddr) == ADDR_STATUS_BASE + i) begin
        rdata = status_i[32*i +: 32];
        rerr  = 1'b0;
      end
    end
    for (int i = 0; i < N_RW; i++) begin
      if (int'(raddr) == ADDR_CTRL_BASE + i) begin
        rdata = ctrl_q[32*i +: 32];
        rerr  = 1'b0;
      end
    end
  end

  // W1C only clears bits in strobed byte lanes
  assign evt_clr = (wreq && evt_hit)
    ? N_EVT'(apply_wstrb(32'h0, wdata, wstrb))
    : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctrl_q     <= CTRL_RESET;
      ctrl_wr_q  <= '0;
      evt_status <= '0;
      evt_mask   <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_wr_q <= wreq ? ctrl_hit : '0;
      for (int i = 0; i < N_RW; i++) begin
        if (wreq && ctrl_hit[i])
          ctrl_q[32*i +: 32] <= apply_wstrb(
            ctrl_q[32*i +: 32], wdata, wstrb);
      end
      if (wreq && mask_hit)
        evt_mask <= N_EVT'(apply_wstrb(
          32'(evt_mask), wdata, wstrb));
      evt_status <= (evt_status & ~evt_clr) | event_i;
      irq_q      <= |(evt_status & evt_mask);
    end
  end

  assign ctrl_o    = ctrl_q;
  assign ctrl_wr_o = ctrl_wr_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_param_regmap.sv
// Randomised self-checking bench for param_regmap against a
// behavioural register-map model.
module tb_param_regmap;
  import regmap_pkg::*;

  localparam logic [31:0]  ID_V    = 32'h0000_0005;
  localparam logic [31:0]  MAGIC_V = 32'hC0DE_5A01;
  localparam logic [127:0] CRST    =
    128'h4444_0004_3333_0003_A5A5_1234_1111_0001;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic [10:0]  awaddr = '0, araddr = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0;
  logic         arvalid = 0, rready = 0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] status_i = '0;
  logic [7:0]   event_i = '0;
  logic [127:0] ctrl_o;
  logic [3:0]   ctrl_wr_o;
  logic         irq_o;

  int vec = 0;
  int bad = 0;
  int wr_cnt[4];

  logic [31:0]  ctrl_m[4];
  logic [7:0]   mask_m, evt_m;
  logic [127:0] status_v;

  always #5 clk = ~clk;

  param_regmap #(
    .ID(ID_V), .ADDRESS_WIDTH(11), .MAGIC(MAGIC_V),
    .N_RW(4), .N_RO(4), .N_EVT(8), .CTRL_RESET(CRST)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .s_axi_if_awaddr(awaddr), .s_axi_if_awvalid(awvalid),
    .s_axi_if_awready(awready),
    .s_axi_if_wdata(wdata), .s_axi_if_wstrb(wstrb),
    .s_axi_if_wvalid(wvalid), .s_axi_if_wready(wready),
    .s_axi_if_bresp(bresp), .s_axi_if_bvalid(bvalid),
    .s_axi_if_bready(bready),
    .s_axi_if_araddr(araddr), .s_axi_if_arvalid(arvalid),
    .s_axi_if_arready(arready),
    .s_axi_if_rdata(rdata), .s_axi_if_rresp(rresp),
    .s_axi_if_rvalid(rvalid), .s_axi_if_rready(rready),
    .status_i(status_i), .event_i(event_i),
    .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr_o), .irq_o(irq_o)
  );

  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (ctrl_wr_o[i]) wr_cnt[i]++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 4; i++) ctrl_m[i] = CRST[32*i +: 32];
    mask_m = '0;
    evt_m  = '0;
  endtask

  function automatic logic [127:0] model_ctrl();
    return {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]};
  endfunction

  function automatic logic [33:0] model_rd(input logic [8:0] w);
    int a;
    a = int'(w);
    if (a == 0) return {2'b00, PCORE_VERSION};
    if (a == 1) return {2'b00, ID_V};
    if (a == 3) return {2'b00, MAGIC_V};
    if (a == 4) return {2'b00, 24'h0, evt_m};
    if (a == 5) return {2'b00, 24'h0, mask_m};
    if (a >= 16 && a < 20)
      return {2'b00, status_v[32*(a-16) +: 32]};
    if (a >= 64 && a < 68) return {2'b00, ctrl_m[a-64]};
    return {2'b10, 32'h0};
  endfunction

  function automatic logic [1:0] model_wr(
    input logic [8:0] w, input logic [31:0] d,
    input logic [3:0] s);
    int a;
    a = int'(w);
    if (a == 4) begin
      if (s[0]) evt_m = evt_m & ~d[7:0];
      return 2'b00;
    end
    if (a == 5) begin
      if (s[0]) mask_m = d[7:0];
      return 2'b00;
    end
    if (a >= 64 && a < 68) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ctrl_m[a-64][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic logic [8:0] rand_word();
    case ($urandom % 10)
      0: return 9'h000;
      1: return 9'h001;
      2: return 9'h002;
      3: return 9'h003;
      4: return 9'h004;
      5: return 9'h005;
      6: return 9'(16 + $urandom % 4);
      7: return 9'(64 + $urandom % 4);
      8: return 9'h044;
      default: return 9'h1FF;
    endcase
  endfunction

  // ---------------- bus drivers ----------------
  // w_lead > 0: W leads AW by w_lead clks; < 0: AW leads
  task automatic axi_write(
    input logic [10:0] addr, input logic [31:0] d,
    input logic [3:0] s, input int w_lead, input int b_hold,
    input logic [7:0] evt_exec, output logic [1:0] resp,
    output logic irq_at_b, output int hold_err);
    int cyc, aw_dly, w_dly;
    logic aw_done, w_done, aw_hs, w_hs;
    aw_dly = w_lead > 0 ? w_lead : 0;
    w_dly  = w_lead < 0 ? -w_lead : 0;
    awaddr = addr; wdata = d; wstrb = s;
    aw_done = 0; w_done = 0; cyc = 0; hold_err = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
    end
    awvalid = 0; wvalid = 0;
    event_i = evt_exec;
    @(posedge clk); #1;
    event_i = '0;
    cyc = 0;
    while (bvalid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    vec++;
    if (bvalid !== 1'b1) begin
      bad++;
      $display("FAIL wr_timeout addr=%h bvalid=%b want 1",
               addr, bvalid);
    end
    resp = bresp;
    irq_at_b = irq_o;
    for (int i = 0; i < b_hold; i++) begin
      if (!(bvalid === 1 && awready === 0 && wready === 0))
        hold_err++;
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(
    input logic [10:0] addr, output logic [31:0] d,
    output logic [1:0] resp, output int lat);
    int cyc;
    araddr = addr; arvalid = 1; cyc = 0;
    while (arready !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    arvalid = 0;
    lat = 1;
    while (rvalid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = rdata; resp = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_i = 1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      bad++;
      $display("FAIL rst_hs got=%b want 00000",
               {awready, wready, arready, bvalid, rvalid});
    end
    vec++;
    if (rdata !== 32'h0 || ctrl_wr_o !== 4'h0 || irq_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_out rdata=%h wr=%h irq=%b want 0/0/0",
               rdata, ctrl_wr_o, irq_o);
    end
    vec++;
    if (ctrl_o !== CRST) begin
      bad++;
      $display("FAIL rst_ctrl got=%h want %h", ctrl_o, CRST);
    end
    reset_i = 0;
    model_reset();
    @(posedge clk); #1;
    vec++;
    if (awready !== 1 || wready !== 1 || arready !== 1) begin
      bad++;
      $display("FAIL idle_ready got=%b%b%b want 111",
               awready, wready, arready);
    end
  endtask

  task automatic test_id_regs();
    logic [31:0] d, exp_d[3];
    logic [10:0] a[3];
    logic [1:0]  r;
    int lat;
    a = '{11'h000, 11'h004, 11'h00C};
    exp_d = '{PCORE_VERSION, ID_V, MAGIC_V};
    for (int i = 0; i < 3; i++) begin
      axi_read(a[i], d, r, lat);
      vec++;
      if (d !== exp_d[i] || r !== 2'b00 || lat != 1) begin
        bad++;
        $display("FAIL id_read a=%h got=%h/%b/%0d want %h/00/1",
                 a[i], d, r, lat, exp_d[i]);
      end
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r, mr;
    logic ib;
    int he;
    for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    axi_write(11'h104, 32'hDEADBEEF, 4'b0011, 3, 5, 8'h0,
              r, ib, he);
    mr = model_wr(9'h041, 32'hDEADBEEF, 4'b0011);
    vec++;
    if (r !== mr) begin
      bad++;
      $display("FAIL wfirst_bresp got=%b want %b", r, mr);
    end
    vec++;
    if (ctrl_o[63:32] !== 32'hA5A5_BEEF) begin
      bad++;
      $display("FAIL wfirst_ctrl got=%h want a5a5beef",
               ctrl_o[63:32]);
    end
    vec++;
    if (wr_cnt[1] != 1 || wr_cnt[0] + wr_cnt[2] + wr_cnt[3] != 0)
    begin
      bad++;
      $display("FAIL wfirst_pulse got=%0d,%0d,%0d,%0d want 0,1,0,0",
               wr_cnt[0], wr_cnt[1], wr_cnt[2], wr_cnt[3]);
    end
    vec++;
    if (he != 0) begin
      bad++;
      $display("FAIL wfirst_bhold errs=%0d want 0", he);
    end
  endtask

  task automatic test_unmapped();
    logic [1:0] r;
    logic [31:0] d;
    logic ib;
    int he, lat;
    axi_write(11'h040, 32'hFFFF_FFFF, 4'hF, 0, 0, 8'h0, r, ib, he);
    vec++;
    if (r !== 2'b10) begin
      bad++;
      $display("FAIL ro_write_bresp got=%b want 10", r);
    end
    axi_read(11'h040, d, r, lat);
    vec++;
    if (d !== status_v[31:0] || r !== 2'b00) begin
      bad++;
      $display("FAIL status_read got=%h/%b want %h/00",
               d, r, status_v[31:0]);
    end
    axi_read(11'h7FF, d, r, lat);
    vec++;
    if (d !== 32'h0 || r !== 2'b10) begin
      bad++;
      $display("FAIL unmapped_read got=%h/%b want 0/10", d, r);
    end
    axi_write(11'h110, 32'h1234_5678, 4'hF, -2, 0, 8'h0, r, ib, he);
    vec++;
    if (r !== 2'b10 || ctrl_o !== model_ctrl()) begin
      bad++;
      $display("FAIL unmapped_write got=%b/%h want 10/%h",
               r, ctrl_o, model_ctrl());
    end
  endtask

  task automatic test_events();
    logic [1:0] r;
    logic [31:0] d;
    logic ib;
    int he, lat;
    axi_write(11'h014, 32'h4, 4'hF, 0, 0, 8'h0, r, ib, he);
    r = model_wr(9'h005, 32'h4, 4'hF);
    event_i = 8'h24;
    @(posedge clk); #1;
    event_i = '0;
    evt_m = evt_m | 8'h24;
    vec++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_reg_delay got=%b want 0", irq_o);
    end
    @(posedge clk); #1;
    vec++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("FAIL irq_rise got=%b want 1", irq_o);
    end
    // clear collides with a fresh event on the same bit
    axi_write(11'h010, 32'h4, 4'b0001, 0, 0, 8'h04, r, ib, he);
    evt_m = (evt_m & ~8'h04) | 8'h04;
    axi_read(11'h010, d, r, lat);
    vec++;
    if (d !== {24'h0, evt_m} || irq_o !== 1'b1) begin
      bad++;
      $display("FAIL w1c_set_wins got=%h/%b want %h/1",
               d, irq_o, evt_m);
    end
    axi_write(11'h010, 32'h4, 4'b1110, 1, 0, 8'h0, r, ib, he);
    r = model_wr(9'h004, 32'h4, 4'b1110);
    axi_read(11'h010, d, r, lat);
    vec++;
    if (d !== {24'h0, evt_m}) begin
      bad++;
      $display("FAIL w1c_strb got=%h want %h", d, evt_m);
    end
    axi_write(11'h010, 32'h4, 4'hF, 0, 0, 8'h0, r, ib, he);
    r = model_wr(9'h004, 32'h4, 4'hF);
    vec++;
    if (ib !== 1'b1 || irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_fall got=%b,%b want 1,0", ib, irq_o);
    end
    axi_read(11'h010, d, r, lat);
    vec++;
    if (d !== {24'h0, evt_m}) begin
      bad++;
      $display("FAIL w1c_clear got=%h want %h", d, evt_m);
    end
  endtask

  task automatic test_random();
    logic [8:0] w;
    logic [31:0] d, dd;
    logic [3:0] s;
    logic [1:0] r, mr;
    logic [33:0] e;
    logic ib;
    int he, lat;
    for (int n = 0; n < 30; n++) begin
      w = rand_word();
      d = $urandom;
      s = 4'($urandom);
      axi_write({w, 2'($urandom)}, d, s,
                int'($urandom % 5) - 2, int'($urandom % 3),
                8'h0, r, ib, he);
      mr = model_wr(w, d, s);
      vec++;
      if (r !== mr || ctrl_o !== model_ctrl()) begin
        bad++;
        $display("FAIL rnd_write w=%h got=%b/%h want %b/%h",
                 w, r, ctrl_o, mr, model_ctrl());
      end
      w = rand_word();
      axi_read({w, 2'b00}, dd, r, lat);
      e = model_rd(w);
      vec++;
      if ({r, dd} !== e || lat != 1) begin
        bad++;
        $display("FAIL rnd_read w=%h got=%b/%h/%0d want %b/%h/1",
                 w, r, dd, lat, e[33:32], e[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] q[$];
    logic [33:0] e;
    logic [31:0] pd;
    logic [1:0] pr;
    logic ar_hs, r_hs, hold;
    for (int c = 0; c < 60; c++) begin
      arvalid = c < 50;
      araddr = {rand_word(), 2'b00};
      rready = c >= 50 ? 1'b1 : 1'($urandom);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      hold  = rvalid && !rready;
      pd = rdata; pr = rresp;
      if (ar_hs) q.push_back(model_rd(araddr[10:2]));
      @(posedge clk); #1;
      if (hold) begin
        vec++;
        if (rvalid !== 1'b1 || rdata !== pd || rresp !== pr) begin
          bad++;
          $display("FAIL b2b_stable got=%b/%h/%b want 1/%h/%b",
                   rvalid, rdata, rresp, pd, pr);
        end
      end
      if (r_hs) begin
        vec++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra got=%h want none", pd);
        end else begin
          e = q.pop_front();
          if ({pr, pd} !== e) begin
            bad++;
            $display("FAIL b2b_data got=%b/%h want %b/%h",
                     pr, pd, e[33:32], e[31:0]);
          end
        end
      end
    end
    arvalid = 0; rready = 0;
    vec++;
    if (q.size() != 0 || rvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain left=%0d rvalid=%b want 0/0",
               q.size(), rvalid);
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] r;
    logic [31:0] d;
    logic ib, aw_hs, w_hs, ar_hs;
    int he, lat;
    axi_write(11'h014, 32'hFF, 4'hF, 0, 0, 8'h0, r, ib, he);
    r = model_wr(9'h005, 32'hFF, 4'hF);
    event_i = 8'h01;
    @(posedge clk); #1;
    event_i = '0;
    @(posedge clk); #1;
    awaddr = 11'h108; wdata = 32'h1357_9BDF; wstrb = 4'hF;
    araddr = 11'h000;
    awvalid = 1; wvalid = 1; arvalid = 1;
    bready = 0; rready = 0;
    for (int c = 0; c < 10 && !(bvalid && rvalid); c++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 0;
      if (w_hs) wvalid = 0;
      if (ar_hs) arvalid = 0;
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    vec++;
    if (bvalid !== 1 || rvalid !== 1 || irq_o !== 1) begin
      bad++;
      $display("FAIL pre_reset got b=%b r=%b irq=%b want 1/1/1",
               bvalid, rvalid, irq_o);
    end
    reset_i = 1;
    @(posedge clk); #1;
    vec++;
    if (bvalid !== 0 || rvalid !== 0 || irq_o !== 0 ||
        ctrl_wr_o !== 4'h0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset b=%b r=%b irq=%b wr=%h rd=%h want 0",
               bvalid, rvalid, irq_o, ctrl_wr_o, rdata);
    end
    vec++;
    if (ctrl_o !== CRST) begin
      bad++;
      $display("FAIL mid_reset_ctrl got=%h want %h", ctrl_o, CRST);
    end
    reset_i = 0;
    model_reset();
    @(posedge clk); #1;
    axi_read(11'h010, d, r, lat);
    vec++;
    if (d !== 32'h0 || r !== 2'b00) begin
      bad++;
      $display("FAIL post_reset_evt got=%h/%b want 0/00", d, r);
    end
  endtask

  initial begin
    status_v = {$urandom, $urandom, $urandom, $urandom};
    status_i = status_v;
    for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    model_reset();
    test_reset();
    test_id_regs();
    test_w_before_aw();
    test_unmapped();
    test_events();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
